// File: rtl/alu_ctrl_stage.sv
// ALU-control decode stage between ID and EX: opcode/funct -> ALU code with illegal flag,
// valid/ready on both sides, and a multi-cycle hold after MULT/DIV.
module alu_ctrl_stage #(
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned MULDIV_LAT = 4,
    parameter bit          EXT_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_op,
    input  logic [5:0]         in_funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_illegal,
    output logic               out_muldiv,
    output logic               busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
    localparam bit MULDIV_MULTI = (MULDIV_LAT > 1);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [ALUOP_W-1:0] out_aluop_q, out_aluop_d;
    logic               out_illegal_q, out_illegal_d;
    logic               out_muldiv_q, out_muldiv_d;

    logic [3:0] dec_code;
    logic       dec_legal;
    logic       dec_muldiv;
    logic       in_xfer;
    logic       out_xfer;

    // Instruction decode; EXT_EN gates the extended logic/compare ops.
    always_comb begin
        dec_code   = 4'd0;
        dec_legal  = 1'b1;
        dec_muldiv = 1'b0;
        if (in_op == 6'h00) begin
            case (in_funct)
                6'h00, 6'h04:               dec_code = 4'd0;
                6'h03, 6'h07:               dec_code = 4'd1;
                6'h02, 6'h06:               dec_code = 4'd2;
                6'h18: begin                dec_code = 4'd3; dec_muldiv = 1'b1; end
                6'h1A: begin                dec_code = 4'd4; dec_muldiv = 1'b1; end
                6'h20, 6'h21, 6'h08, 6'h0C: dec_code = 4'd5;
                6'h22, 6'h23:               dec_code = 4'd6;
                6'h24:                      dec_code = 4'd7;
                6'h25:                      dec_code = 4'd8;
                6'h26: begin                dec_code = 4'd9;  dec_legal = EXT_EN; end
                6'h27: begin                dec_code = 4'd10; dec_legal = EXT_EN; end
                6'h2A:                      dec_code = 4'd11;
                6'h2B: begin                dec_code = 4'd12; dec_legal = EXT_EN; end
                default:                    dec_legal = 1'b0;
            endcase
        end else begin
            case (in_op)
                6'h08, 6'h09, 6'h02, 6'h03, 6'h0F: dec_code = 4'd5;
                6'h20, 6'h21, 6'h23, 6'h24,
                6'h25, 6'h28, 6'h29, 6'h2B:        dec_code = 4'd5;
                6'h0C:                             dec_code = 4'd7;
                6'h0D:                             dec_code = 4'd8;
                6'h0E: begin                       dec_code = 4'd9;  dec_legal = EXT_EN; end
                6'h0A, 6'h01, 6'h06, 6'h07:        dec_code = 4'd11;
                6'h0B: begin                       dec_code = 4'd12; dec_legal = EXT_EN; end
                6'h04, 6'h05:                      dec_code = 4'd6;
                default:                           dec_legal = 1'b0;
            endcase
        end
        if (!dec_legal) begin
            dec_code   = 4'd0;
            dec_muldiv = 1'b0;
        end
    end

    assign in_ready = ~flush & ((state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready));
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid_q & out_ready;

    // State register and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            out_aluop_q   <= '0;
            out_illegal_q <= 1'b0;
            out_muldiv_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            out_aluop_q   <= out_aluop_d;
            out_illegal_q <= out_illegal_d;
            out_muldiv_q  <= out_muldiv_d;
        end
    end

    // Next-state logic; flush drops everything including a same-cycle instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_EMPTY, S_FULL: begin
                    if (in_xfer) begin
                        if (dec_muldiv && MULDIV_MULTI) begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = S_FULL;
                        end
                    end else if (out_xfer) begin
                        state_d = S_EMPTY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register next values; data only changes on an accepting edge.
    always_comb begin
        out_valid_d   = (state_d == S_FULL);
        busy_d        = (state_d == S_BUSY);
        out_aluop_d   = out_aluop_q;
        out_illegal_d = out_illegal_q;
        out_muldiv_d  = out_muldiv_q;
        if (in_xfer) begin
            out_aluop_d   = ALUOP_W'(dec_code);
            out_illegal_d = ~dec_legal;
            out_muldiv_d  = dec_muldiv;
        end
    end

    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_aluop   = out_aluop_q;
    assign out_illegal = out_illegal_q;
    assign out_muldiv  = out_muldiv_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: two instances (LAT=4/EXT=1 and LAT=1/EXT=0, wide aluop)
// driven together, compared every cycle against a transaction-timing reference model.
module tb_alu_ctrl_stage;

    logic clk;
    logic rst, flush, in_valid, out_ready;
    logic [5:0] in_op, in_funct;

    logic       rdy_a, ov_a, ill_a, md_a, busy_a;
    logic [3:0] aluop_a;
    logic       rdy_b, ov_b, ill_b, md_b, busy_b;
    logic [5:0] aluop_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: result pending, cycles left until visible, payload.
    int m_lat[2] = '{4, 1};
    bit m_ext[2] = '{1'b1, 1'b0};
    bit m_pend[2];
    int m_left[2];
    int m_code[2];
    bit m_ill[2];
    bit m_md[2];
    bit m_rdy[2];

    logic [5:0] rfun [20] = '{6'h00, 6'h04, 6'h03, 6'h07, 6'h02, 6'h06, 6'h18, 6'h1A, 6'h20, 6'h21,
                              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h0C};
    logic [5:0] iops [23] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h20, 6'h21, 6'h23,
                              6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05, 6'h01, 6'h06, 6'h07,
                              6'h02, 6'h03, 6'h0F};

    alu_ctrl_stage #(.ALUOP_W(4), .MULDIV_LAT(4), .EXT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_op(in_op), .in_funct(in_funct), .out_valid(ov_a), .out_ready(out_ready),
        .out_aluop(aluop_a), .out_illegal(ill_a), .out_muldiv(md_a), .busy(busy_a));

    alu_ctrl_stage #(.ALUOP_W(6), .MULDIV_LAT(1), .EXT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_op(in_op), .in_funct(in_funct), .out_valid(ov_b), .out_ready(out_ready),
        .out_aluop(aluop_b), .out_illegal(ill_b), .out_muldiv(md_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decode table written straight from the instruction list.
    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn, input bit ext,
                                       output int code, output bit ill, output bit md);
        code = -1;
        md   = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h00, 6'h04: code = 0;
                6'h03, 6'h07: code = 1;
                6'h02, 6'h06: code = 2;
                6'h18: begin code = 3; md = 1'b1; end
                6'h1A: begin code = 4; md = 1'b1; end
                6'h20, 6'h21, 6'h08, 6'h0C: code = 5;
                6'h22, 6'h23: code = 6;
                6'h24: code = 7;
                6'h25: code = 8;
                6'h26: code = ext ? 9 : -1;
                6'h27: code = ext ? 10 : -1;
                6'h2A: code = 11;
                6'h2B: code = ext ? 12 : -1;
                default: code = -1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h02, 6'h03, 6'h0F: code = 5;
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: code = 5;
                6'h0C: code = 7;
                6'h0D: code = 8;
                6'h0E: code = ext ? 9 : -1;
                6'h0A, 6'h01, 6'h06, 6'h07: code = 11;
                6'h0B: code = ext ? 12 : -1;
                6'h04, 6'h05: code = 6;
                default: code = -1;
            endcase
        end
        ill = (code < 0);
        if (ill) begin
            code = 0;
            md   = 1'b0;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_left[i] = 0; m_code[i] = 0; m_ill[i] = 1'b0; m_md[i] = 1'b0;
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic ov, input logic bsy,
                              input logic [31:0] code, input logic ill, input logic md);
        bit exp_ov;
        exp_ov   = m_pend[i] && (m_left[i] == 0);
        m_rdy[i] = !flush && (!m_pend[i] || (exp_ov && out_ready));
        chk($sformatf("in_ready[%0d]", i), 32'(rdy), 32'(m_rdy[i]));
        chk($sformatf("out_valid[%0d]", i), 32'(ov), 32'(exp_ov));
        chk($sformatf("busy[%0d]", i), 32'(bsy), 32'(m_pend[i] && m_left[i] > 0));
        if (exp_ov) begin
            chk($sformatf("aluop[%0d]", i), code, 32'(m_code[i]));
            chk($sformatf("illegal[%0d]", i), 32'(ill), 32'(m_ill[i]));
            chk($sformatf("muldiv[%0d]", i), 32'(md), 32'(m_md[i]));
        end
    endtask

    task automatic model_step();
        bit xin, xout;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pend[i] = 1'b0; m_left[i] = 0; m_code[i] = 0; m_ill[i] = 1'b0; m_md[i] = 1'b0;
            end else if (flush) begin
                m_pend[i] = 1'b0;
                m_left[i] = 0;
            end else begin
                xin  = in_valid && m_rdy[i];
                xout = m_pend[i] && (m_left[i] == 0) && out_ready;
                if (xin) begin
                    ref_decode(in_op, in_funct, m_ext[i], m_code[i], m_ill[i], m_md[i]);
                    m_pend[i] = 1'b1;
                    m_left[i] = m_md[i] ? m_lat[i] - 1 : 0;
                end else if (xout) begin
                    m_pend[i] = 1'b0;
                end else if (m_pend[i] && m_left[i] > 0) begin
                    m_left[i]--;
                end
            end
        end
    endtask

    // One clock: drive just after the edge, check at negedge, advance model at the edge.
    task automatic cyc(input bit v, input logic [5:0] op, input logic [5:0] fn,
                       input bit ordy, input bit fl, input bit r);
        in_valid = v; in_op = op; in_funct = fn; out_ready = ordy; flush = fl; rst = r;
        @(negedge clk);
        check_inst(0, rdy_a, ov_a, busy_a, 32'(aluop_a), ill_a, md_a);
        check_inst(1, rdy_b, ov_b, busy_b, 32'(aluop_b), ill_b, md_b);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int r;
        bit v, ordy, fl, rs;
        logic [5:0] op, fn;

        // Reset held two edges with in_valid high.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_op = 6'h00; in_funct = 6'h20;
        model_reset();
        @(posedge clk);
        #1;
        cyc(1'b1, 6'h00, 6'h20, 1'b1, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_aluop", 32'(aluop_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(rdy_a), 32'd1);

        // Throughput: SUB then ORI back to back.
        cyc(1'b1, 6'h00, 6'h22, 1'b1, 1'b0, 1'b0);
        chk("tp_sub", 32'(aluop_a), 32'd6);
        chk("tp_sub_valid", 32'(ov_a), 32'd1);
        cyc(1'b1, 6'h0D, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("tp_ori", 32'(aluop_a), 32'd8);
        chk("tp_ori_illegal", 32'(ill_a), 32'd0);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);

        // Backpressure on ADDI, then release accepts ANDI in the same cycle.
        cyc(1'b1, 6'h08, 6'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 6'h0C, 6'h00, 1'b0, 1'b0, 1'b0);
            chk("bp_hold", 32'(aluop_a), 32'd5);
        end
        cyc(1'b1, 6'h0C, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("bp_release", 32'(aluop_a), 32'd7);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);

        // MULT: three busy cycles, result visible four cycles after acceptance.
        cyc(1'b1, 6'h00, 6'h18, 1'b1, 1'b0, 1'b0);
        chk("mult_busy1", 32'(busy_a), 32'd1);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("mult_busy2", 32'(busy_a), 32'd1);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("mult_busy3", 32'(busy_a), 32'd1);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("mult_valid", 32'(ov_a), 32'd1);
        chk("mult_aluop", 32'(aluop_a), 32'd3);
        chk("mult_muldiv", 32'(md_a), 32'd1);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);

        // Flush mid-BUSY kills the DIV; next ADD is taken right after.
        cyc(1'b1, 6'h00, 6'h1A, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0);
        chk("flush_busy", 32'(busy_a), 32'd0);
        chk("flush_valid", 32'(ov_a), 32'd0);
        cyc(1'b1, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
        chk("flush_add", 32'(aluop_a), 32'd5);
        chk("flush_add_md", 32'(md_a), 32'd0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);

        // Illegal opcode and EXT_EN-dependent SLTU.
        cyc(1'b1, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("ill_flag", 32'(ill_a), 32'd1);
        chk("ill_aluop", 32'(aluop_a), 32'd0);
        cyc(1'b1, 6'h00, 6'h2B, 1'b1, 1'b0, 1'b0);
        chk("sltu_ext1", 32'(aluop_a), 32'd12);
        chk("sltu_ext0_ill", 32'(ill_b), 32'd1);
        chk("sltu_ext0_aluop", 32'(aluop_b), 32'd0);
        cyc(1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                op = 6'h00;
                fn = ($urandom_range(0, 3) != 0) ? rfun[$urandom_range(0, 19)] : 6'($urandom);
            end else if (r < 9) begin
                op = iops[$urandom_range(0, 22)];
                fn = 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 29) == 0);
            rs   = ($urandom_range(0, 99) == 0);
            cyc(v, op, fn, ordy, fl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
